// File: rtl/rtype_sequencer.sv
// rtype_sequencer: hardwired fetch/execute control for register-to-register
// ALU instructions. Drives DataPath strobes, handshakes with the ALU
// (start/finished) under a timeout, and handles HI/LO writeback for MUL/DIV.
// All outputs are registered and decoded from the next state, so every
// strobe is high for exactly the cycle the FSM sits in its state.
module rtype_sequencer #(
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     OP_WIDTH      = 5,
  parameter int                     REG_SEL_WIDTH = 4,
  parameter logic [OP_WIDTH-1:0]    OPC_MUL       = 5'b01110,
  parameter logic [OP_WIDTH-1:0]    OPC_DIV       = 5'b01111,
  parameter int                     ALU_TIMEOUT   = 64
) (
  input  logic                     Clock,
  input  logic                     clear,
  input  logic                     run,
  input  logic [DATA_WIDTH-1:0]    IR,
  input  logic                     finished,
  output logic                     PCout,
  output logic                     MARin,
  output logic                     IncPC,
  output logic                     RZin,
  output logic                     RZLOout,
  output logic                     RZHIout,
  output logic                     PCin,
  output logic                     Read,
  output logic                     MDRin,
  output logic                     MDRout,
  output logic                     IRin,
  output logic                     RFout,
  output logic                     RYin,
  output logic                     RFin,
  output logic                     RHIin,
  output logic                     RLOin,
  output logic [REG_SEL_WIDTH-1:0] RFSelect,
  output logic [OP_WIDTH-1:0]      opSelect,
  output logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  // IR field layout: opcode at the top, then Ra, Rb, Rc (MSB-first).
  localparam int OP_LSB = DATA_WIDTH - OP_WIDTH;
  localparam int RA_MSB = OP_LSB - 1;
  localparam int RB_MSB = RA_MSB - REG_SEL_WIDTH;
  localparam int RC_MSB = RB_MSB - REG_SEL_WIDTH;
  localparam int LOW_W  = RC_MSB + 1 - REG_SEL_WIDTH;

  localparam int                CNT_W    = $clog2(ALU_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, WAIT_ALU, T5, T6, DONE
  } state_t;

  // Registered control word; one field per DataPath/ALU output.
  typedef struct packed {
    logic                     pc_out;
    logic                     mar_in;
    logic                     inc_pc;
    logic                     rz_in;
    logic                     rz_lo_out;
    logic                     rz_hi_out;
    logic                     pc_in;
    logic                     read;
    logic                     mdr_in;
    logic                     mdr_out;
    logic                     ir_in;
    logic                     rf_out;
    logic                     ry_in;
    logic                     rf_in;
    logic                     rhi_in;
    logic                     rlo_in;
    logic [REG_SEL_WIDTH-1:0] rf_sel;
    logic [OP_WIDTH-1:0]      op_sel;
    logic                     start;
    logic                     busy;
    logic                     done;
  } ctl_t;

  state_t                   state, state_nxt;
  ctl_t                     ctl_q, ctl_nxt;
  logic [OP_WIDTH-1:0]      op_q;
  logic [REG_SEL_WIDTH-1:0] ra_q, rb_q, rc_q;
  logic [CNT_W-1:0]         cnt;
  logic                     hilo;
  logic                     alu_timeout;

  logic [OP_WIDTH-1:0]      ir_op;
  logic [REG_SEL_WIDTH-1:0] ir_ra, ir_rb, ir_rc;

  assign ir_op = IR[DATA_WIDTH-1 -: OP_WIDTH];
  assign ir_ra = IR[RA_MSB -: REG_SEL_WIDTH];
  assign ir_rb = IR[RB_MSB -: REG_SEL_WIDTH];
  assign ir_rc = IR[RC_MSB -: REG_SEL_WIDTH];

  // Low IR bits carry no R-type field; fold them away explicitly.
  if (LOW_W > 0) begin : g_unused
    logic unused_ir_low;
    assign unused_ir_low = ^IR[LOW_W-1:0];
  end

  assign hilo        = (op_q == OPC_MUL) || (op_q == OPC_DIV);
  assign alu_timeout = (state == WAIT_ALU) && !finished && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge Clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and Moore output decode of the next state.
  always_comb begin
    state_nxt = state;
    ctl_nxt   = '0;
    unique case (state)
      IDLE:     if (run) state_nxt = T0;
      T0:       state_nxt = T1;
      T1:       state_nxt = T2;
      T2:       state_nxt = T3;
      T3:       state_nxt = T4;
      T4:       state_nxt = WAIT_ALU;
      WAIT_ALU: begin
        // finished wins over a timeout landing on the same cycle
        if (finished)         state_nxt = T5;
        else if (alu_timeout) state_nxt = DONE;
      end
      T5:       state_nxt = hilo ? T6 : DONE;
      T6:       state_nxt = DONE;
      DONE:     state_nxt = run ? T0 : IDLE;
      default:  state_nxt = IDLE;
    endcase

    ctl_nxt.busy = (state_nxt != IDLE);
    unique case (state_nxt)
      T0: begin
        ctl_nxt.pc_out = 1'b1;
        ctl_nxt.mar_in = 1'b1;
        ctl_nxt.inc_pc = 1'b1;
        ctl_nxt.rz_in  = 1'b1;
      end
      T1: begin
        ctl_nxt.rz_lo_out = 1'b1;
        ctl_nxt.pc_in     = 1'b1;
        ctl_nxt.read      = 1'b1;
        ctl_nxt.mdr_in    = 1'b1;
      end
      T2: begin
        ctl_nxt.mdr_out = 1'b1;
        ctl_nxt.ir_in   = 1'b1;
      end
      T3: begin
        // fields are latched on this same edge, so take Rb straight from IR
        ctl_nxt.rf_sel = ir_rb;
        ctl_nxt.rf_out = 1'b1;
        ctl_nxt.ry_in  = 1'b1;
      end
      T4: begin
        ctl_nxt.rf_sel = rc_q;
        ctl_nxt.rf_out = 1'b1;
        ctl_nxt.rz_in  = 1'b1;
        ctl_nxt.op_sel = op_q;
        ctl_nxt.start  = 1'b1;
      end
      WAIT_ALU: begin
        ctl_nxt.op_sel = op_q;
        ctl_nxt.rz_in  = 1'b1;
      end
      T5: begin
        ctl_nxt.rz_lo_out = 1'b1;
        if (hilo) begin
          ctl_nxt.rlo_in = 1'b1;
        end else begin
          ctl_nxt.rf_sel = ra_q;
          ctl_nxt.rf_in  = 1'b1;
        end
      end
      T6: begin
        ctl_nxt.rz_hi_out = 1'b1;
        ctl_nxt.rhi_in    = 1'b1;
      end
      DONE:    ctl_nxt.done = 1'b1;
      default: ;
    endcase
  end

  // Output register.
  always_ff @(posedge Clock) begin
    if (!clear) ctl_q <= '0;
    else        ctl_q <= ctl_nxt;
  end

  // Capture opcode and register fields on entry to T3; later IR changes are ignored.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
    end else if (state_nxt == T3) begin
      op_q <= ir_op;
      ra_q <= ir_ra;
      rb_q <= ir_rb;
      rc_q <= ir_rc;
    end
  end

  // WAIT_ALU cycle counter; held at zero outside WAIT_ALU so each entry starts fresh.
  always_ff @(posedge Clock) begin
    if (!clear)                 cnt <= '0;
    else if (state != WAIT_ALU) cnt <= '0;
    else                        cnt <= cnt + CNT_W'(1);
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge Clock) begin
    if (!clear)           error <= 1'b0;
    else if (alu_timeout) error <= 1'b1;
  end

  assign PCout    = ctl_q.pc_out;
  assign MARin    = ctl_q.mar_in;
  assign IncPC    = ctl_q.inc_pc;
  assign RZin     = ctl_q.rz_in;
  assign RZLOout  = ctl_q.rz_lo_out;
  assign RZHIout  = ctl_q.rz_hi_out;
  assign PCin     = ctl_q.pc_in;
  assign Read     = ctl_q.read;
  assign MDRin    = ctl_q.mdr_in;
  assign MDRout   = ctl_q.mdr_out;
  assign IRin     = ctl_q.ir_in;
  assign RFout    = ctl_q.rf_out;
  assign RYin     = ctl_q.ry_in;
  assign RFin     = ctl_q.rf_in;
  assign RHIin    = ctl_q.rhi_in;
  assign RLOin    = ctl_q.rlo_in;
  assign RFSelect = ctl_q.rf_sel;
  assign opSelect = ctl_q.op_sel;
  assign start    = ctl_q.start;
  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Directed bench for rtype_sequencer: checks the full per-cycle control word
// for ordinary, MUL/DIV, timeout, back-to-back, reset-in-flight and
// IR-change cases.
module tb_rtype_sequencer;

  localparam int TO = 4;

  // strobe word bit order: PCout MARin IncPC RZin RZLOout RZHIout PCin Read
  //                        MDRin MDRout IRin RFout RYin RFin RHIin RLOin
  localparam logic [15:0] S_T0  = 16'hF000;
  localparam logic [15:0] S_T1  = 16'h0B80;
  localparam logic [15:0] S_T2  = 16'h0060;
  localparam logic [15:0] S_T3  = 16'h0018;
  localparam logic [15:0] S_T4  = 16'h1010;
  localparam logic [15:0] S_WT  = 16'h1000;
  localparam logic [15:0] S_T5  = 16'h0804;
  localparam logic [15:0] S_T5H = 16'h0801;
  localparam logic [15:0] S_T6  = 16'h0402;

  logic        Clock = 1'b0;
  logic        clear, run, finished;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, RZin, RZLOout, RZHIout, PCin, Read;
  logic MDRin, MDRout, IRin, RFout, RYin, RFin, RHIin, RLOin;
  logic [3:0]  RFSelect;
  logic [4:0]  opSelect;
  logic        start, busy, done, error;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;
  logic err_model = 1'b0;

  rtype_sequencer #(.ALU_TIMEOUT(TO)) dut (
    .Clock(Clock), .clear(clear), .run(run), .IR(IR), .finished(finished),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin),
    .RZLOout(RZLOout), .RZHIout(RZHIout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .RFout(RFout),
    .RYin(RYin), .RFin(RFin), .RHIin(RHIin), .RLOin(RLOin),
    .RFSelect(RFSelect), .opSelect(opSelect), .start(start),
    .busy(busy), .done(done), .error(error)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (done === 1'b1) done_cnt++;

  function automatic logic [31:0] obs();
    return {3'b0, PCout, MARin, IncPC, RZin, RZLOout, RZHIout, PCin, Read,
            MDRin, MDRout, IRin, RFout, RYin, RFin, RHIin, RLOin,
            RFSelect, opSelect, start, busy, done, error};
  endfunction

  function automatic logic [31:0] ew(input logic [15:0] s, input logic [3:0] rf,
                                     input logic [4:0] op, input logic st,
                                     input logic bz, input logic dn);
    return {3'b0, s, rf, op, st, bz, dn, err_model};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One instruction from IDLE/DONE. fin_w: WAIT cycle during which finished
  // rises (-1 = already high on entry, 0 = never).
  task automatic instr(input string tag, input logic [31:0] ir, input int fin_w,
                       input bit keep_run, input bit ir_swap);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit hilo, tmo;
    int w_exp;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    hilo  = (op == 5'b01110) || (op == 5'b01111);
    tmo   = (fin_w == 0) || (fin_w > TO);
    w_exp = (fin_w < 0) ? 1 : (tmo ? TO : fin_w);
    IR = ir; run = 1'b1;
    step; chk({tag, ".t0"}, obs(), ew(S_T0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    if (!keep_run) run = 1'b0;
    step; chk({tag, ".t1"}, obs(), ew(S_T1, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    step; chk({tag, ".t2"}, obs(), ew(S_T2, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0));
    step; chk({tag, ".t3"}, obs(), ew(S_T3, rb, 5'd0, 1'b0, 1'b1, 1'b0));
    step; chk({tag, ".t4"}, obs(), ew(S_T4, rc, op, 1'b1, 1'b1, 1'b0));
    if (ir_swap) IR = ~ir;
    if (fin_w < 0) finished = 1'b1;
    for (int w = 1; w <= w_exp; w++) begin
      step; chk({tag, ".wait"}, obs(), ew(S_WT, 4'd0, op, 1'b0, 1'b1, 1'b0));
      if (w == fin_w) finished = 1'b1;
    end
    if (tmo) begin
      err_model = 1'b1;
      step; chk({tag, ".done"}, obs(), ew(16'h0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b1));
    end else begin
      step; finished = 1'b0;
      if (hilo) chk({tag, ".t5"}, obs(), ew(S_T5H, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0));
      else      chk({tag, ".t5"}, obs(), ew(S_T5, ra, 5'd0, 1'b0, 1'b1, 1'b0));
      if (hilo) begin
        step; chk({tag, ".t6"}, obs(), ew(S_T6, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0));
      end
      step; chk({tag, ".done"}, obs(), ew(16'h0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b1));
    end
  endtask

  initial begin
    clear = 1'b0; run = 1'b0; finished = 1'b0; IR = 32'h0;

    // reset state
    step; step;
    chk("reset", obs(), 32'h0);
    clear = 1'b1;
    step; chk("idle", obs(), 32'h0);

    // ordinary opcode, finished 2 cycles after start (done on 9th edge)
    instr("ord", 32'h28918000, 2, 1'b0, 1'b0);
    step; chk("ord.idle", obs(), ew(16'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // MUL: HI/LO writeback, one extra cycle
    instr("mul", 32'h70918000, 2, 1'b0, 1'b0);
    step; chk("mul.idle", obs(), ew(16'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // DIV with finished already high on entry to WAIT_ALU
    instr("div", mk(5'b01111, 4'd4, 4'd5, 4'd6), -1, 1'b0, 1'b0);
    step; chk("div.idle", obs(), ew(16'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0));

    // ALU timeout: 4 WAIT cycles, sticky error, next instruction still runs
    instr("tmo", 32'h28918000, 0, 1'b0, 1'b0);
    step; chk("tmo.idle", obs(), ew(16'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0));
    instr("post", mk(5'b00011, 4'd7, 4'd8, 4'd9), 3, 1'b0, 1'b0);
    step; chk("post.err", {31'b0, error}, 32'h1);

    // reset while in WAIT_ALU
    IR = mk(5'b00100, 4'd1, 4'd1, 4'd1); run = 1'b1;
    step; run = 1'b0;
    step; step; step; step; step;
    chk("rst.wait", obs(), ew(S_WT, 4'd0, 5'b00100, 1'b0, 1'b1, 1'b0));
    clear = 1'b0;
    step; err_model = 1'b0;
    chk("rst.cleared", obs(), 32'h0);
    clear = 1'b1;
    step; chk("rst.idle", obs(), 32'h0);
    instr("fresh", mk(5'b00010, 4'd10, 4'd11, 4'd12), 2, 1'b0, 1'b0);
    step; chk("fresh.idle", obs(), 32'h0);

    // three back-to-back instructions with run held high
    d0 = done_cnt;
    instr("b2b0", mk(5'b00001, 4'd1, 4'd2, 4'd3), 1, 1'b1, 1'b0);
    instr("b2b1", mk(5'b01110, 4'd4, 4'd5, 4'd6), 2, 1'b1, 1'b0);
    instr("b2b2", mk(5'b10101, 4'd7, 4'd8, 4'd9), 1, 1'b1, 1'b0);
    run = 1'b0;
    step; chk("b2b.idle", obs(), 32'h0);
    chk("b2b.dones", done_cnt - d0, 32'd3);

    // IR changes during WAIT_ALU; T5 must still use the latched Ra
    instr("swap", mk(5'b00110, 4'd9, 4'd2, 4'd3), 2, 1'b0, 1'b1);
    step; chk("swap.idle", obs(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
